// File: rtl/fp_normalize_pack_if.sv
// Handshake bundle for the adder's normalise/pack stage: the operand side
// (mant/exp/sign with valid/ready) and the packed-result side (word plus flags).
interface fp_normalize_pack_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
);
  logic                  in_valid;
  logic                  in_ready;
  logic [FRAC_W+1:0]     mant_in;
  logic [EXP_W-1:0]      exp_in;
  logic                  sign_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [EXP_W+FRAC_W:0] result;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output in_valid, mant_in, exp_in, sign_in, out_ready,
    input  in_ready, out_valid, result, overflow, underflow
  );

  modport slave (
    input  in_valid, mant_in, exp_in, sign_in, out_ready,
    output in_ready, out_valid, result, overflow, underflow
  );
endinterface

// File: rtl/fp_normalize_pack.sv
// Post-add normalise and pack stage of the single-precision adder: one carry
// right-shift or one left shift per cycle, then a truncated IEEE754 word with flags.
module fp_normalize_pack #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                clk,
  input  logic                rst,
  fp_normalize_pack_if.slave  bus
);

  localparam int MANT_W = FRAC_W + 2;
  localparam int WORD_W = EXP_W + FRAC_W + 1;
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [MANT_W-1:0]   r_mant,  w_mant_nxt;
  logic [EXP_W:0]      r_exp,   w_exp_nxt;
  logic                r_sign,  w_sign_nxt;
  logic [WORD_W-1:0]   r_result, w_result_nxt;
  logic                r_ovf,   w_ovf_nxt;
  logic                r_unf,   w_unf_nxt;
  logic [EXP_W:0]      w_exp_inc;

  // One extra exponent bit so the carry increment never wraps.
  assign w_exp_inc = r_exp + EXP_ONE;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mant   <= '0;
      r_exp    <= '0;
      r_sign   <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_mant   <= w_mant_nxt;
      r_exp    <= w_exp_nxt;
      r_sign   <= w_sign_nxt;
      r_result <= w_result_nxt;
      r_ovf    <= w_ovf_nxt;
      r_unf    <= w_unf_nxt;
    end
  end

  // NOTE: every output of this block gets a hold default first, so no path
  // through the case leaves a variable unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_mant_nxt   = r_mant;
    w_exp_nxt    = r_exp;
    w_sign_nxt   = r_sign;
    w_result_nxt = r_result;
    w_ovf_nxt    = r_ovf;
    w_unf_nxt    = r_unf;

    unique case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_mant_nxt  = bus.mant_in;
          w_exp_nxt   = {1'b0, bus.exp_in};
          w_sign_nxt  = bus.sign_in;
          w_state_nxt = S_NORM;
        end
      end

      S_NORM: begin
        if (r_exp == EXP_MAX) begin
          w_result_nxt = {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          w_ovf_nxt    = 1'b1;
          w_state_nxt  = S_DONE;
        end else if (r_mant == '0) begin
          // Exact cancellation always yields +0, whatever the sum sign was.
          w_result_nxt = '0;
          w_state_nxt  = S_DONE;
        end else if (r_mant[MANT_W-1]) begin
          w_mant_nxt  = r_mant >> 1;
          w_exp_nxt   = w_exp_inc;
          w_state_nxt = S_DONE;
          if (w_exp_inc == EXP_MAX) begin
            w_result_nxt = {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            w_ovf_nxt    = 1'b1;
          end else begin
            w_result_nxt = {r_sign, w_exp_inc[EXP_W-1:0], r_mant[FRAC_W:1]};
          end
        end else if (r_mant[FRAC_W]) begin
          w_result_nxt = {r_sign, r_exp[EXP_W-1:0], r_mant[FRAC_W-1:0]};
          w_state_nxt  = S_DONE;
        end else if (r_exp <= EXP_ONE) begin
          // No denormal output: anything that cannot normalise flushes to zero.
          w_result_nxt = {r_sign, {(WORD_W-1){1'b0}}};
          w_unf_nxt    = 1'b1;
          w_state_nxt  = S_DONE;
        end else begin
          w_mant_nxt = r_mant << 1;
          w_exp_nxt  = r_exp - EXP_ONE;
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          w_ovf_nxt   = 1'b0;
          w_unf_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.result    = r_result;
  assign bus.overflow  = r_ovf;
  assign bus.underflow = r_unf;

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Self-checking bench for fp_normalize_pack: directed corner cases, reset
// mid-operation, and random back-to-back operations against a numeric reference.
module tb_fp_normalize_pack;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fp_normalize_pack_if #(.EXP_W(8), .FRAC_W(23)) bus ();

  fp_normalize_pack #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: locate the leading one and derive shift count, exponent and
  // latency directly instead of stepping cycle by cycle.
  function automatic void model(input logic [24:0] m, input int e, input bit s,
                                output logic [31:0] r, output bit ov, output bit un,
                                output int lat);
    int msb;
    int k;
    logic [24:0] mn;
    msb = -1;
    for (int b = 0; b < 25; b++) if (m[b]) msb = b;
    ov = 1'b0; un = 1'b0; lat = 2; r = 32'h0;
    if (e == 255) begin
      r = {s, 8'hFF, 23'h0}; ov = 1'b1;
    end else if (msb < 0) begin
      r = 32'h0;
    end else if (msb == 24) begin
      if (e + 1 == 255) begin r = {s, 8'hFF, 23'h0}; ov = 1'b1; end
      else r = {s, 8'(e + 1), m[23:1]};
    end else begin
      k = 23 - msb;
      if (k == 0 || e - k >= 1) begin
        mn  = m << k;
        r   = {s, 8'(e - k), mn[22:0]};
        lat = 2 + k;
      end else begin
        r   = {s, 31'h0};
        un  = 1'b1;
        lat = 2 + ((e > 1) ? e - 1 : 0);
      end
    end
  endfunction

  task automatic send(input logic [24:0] m, input logic [7:0] e, input bit s);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.mant_in  = m;
    bus.exp_in   = e;
    bus.sign_in  = s;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Returns accept-edge-to-out_valid latency; timed_out set if nothing appears.
  task automatic wait_done(output int lat, output bit timed_out);
    lat = 1;
    timed_out = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (bus.out_valid) begin timed_out = 1'b0; break; end
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic run_directed(input string name, input logic [24:0] m, input logic [7:0] e,
                              input bit s, input logic [31:0] exp_r, input bit exp_ov,
                              input bit exp_un, input int exp_lat);
    int lat;
    bit to;
    send(m, e, s);
    wait_done(lat, to);
    n_checks++;
    if (to) begin
      n_fail++; $display("FAIL %s timeout: out_valid never rose within 40 cycles", name);
    end else begin
      n_checks++;
      if ({bus.result, bus.overflow, bus.underflow} !== {exp_r, exp_ov, exp_un}) begin
        n_fail++;
        $display("FAIL %s result: got %h ov=%b un=%b, expected %h ov=%b un=%b",
                 name, bus.result, bus.overflow, bus.underflow, exp_r, exp_ov, exp_un);
      end
      n_checks++;
      if (lat !== exp_lat) begin
        n_fail++; $display("FAIL %s latency: got %0d, expected %0d", name, lat, exp_lat);
      end
    end
    release_result();
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.result, bus.overflow, bus.underflow} !== {2'b10, 32'h0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h ov=%b un=%b, expected 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.result, bus.overflow, bus.underflow);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_directed("one_plus_one", 25'h1000000, 8'd127, 1'b0, 32'h4000_0000, 1'b0, 1'b0, 2);
    run_directed("neg_1p5",      25'h0C00000, 8'd127, 1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 2);
    run_directed("one_shift",    25'h0400000, 8'd128, 1'b0, 32'h3F80_0000, 1'b0, 1'b0, 3);
  endtask

  task automatic test_flags();
    run_directed("carry_overflow", 25'h1FFFFFF, 8'd254, 1'b0, 32'h7F80_0000, 1'b1, 1'b0, 2);
    run_directed("exp_max_in",     25'h0800000, 8'd255, 1'b1, 32'hFF80_0000, 1'b1, 1'b0, 2);
    run_directed("underflow",      25'h0000001, 8'd10,  1'b0, 32'h0000_0000, 1'b0, 1'b1, 11);
    run_directed("exp1_pack",      25'h0800005, 8'd1,   1'b1, 32'h8080_0005, 1'b0, 1'b0, 2);
    run_directed("max_shift",      25'h0000001, 8'd200, 1'b0, {1'b0, 8'd177, 23'h0}, 1'b0, 1'b0, 25);
  endtask

  task automatic test_zero_hold();
    int lat;
    bit to;
    send(25'h0, 8'd100, 1'b1);
    wait_done(lat, to);
    n_checks++;
    if (to || bus.result !== 32'h0 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_sum: timeout=%b result=%h ov=%b un=%b, expected +0 with no flags",
               to, bus.result, bus.overflow, bus.underflow);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({bus.out_valid, bus.in_ready, bus.result} !== {2'b10, 32'h0}) begin
        n_fail++;
        $display("FAIL zero_hold cycle %0d: out_valid=%b in_ready=%b result=%h, expected 1 0 00000000",
                 c, bus.out_valid, bus.in_ready, bus.result);
      end
    end
    release_result();
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL zero_release: out_valid=%b in_ready=%b, expected 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_norm();
    send(25'h0000010, 8'd120, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.result, bus.overflow, bus.underflow} !== {2'b01, 32'h0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_mid_norm: out_valid=%b in_ready=%b result=%h, expected 0 1 00000000",
               bus.out_valid, bus.in_ready, bus.result);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL dropped_op: out_valid=%b after reset, expected 0", bus.out_valid);
    end
    run_directed("post_reset", 25'h1000000, 8'd127, 1'b0, 32'h4000_0000, 1'b0, 1'b0, 2);
  endtask

  task automatic test_back_to_back();
    logic [24:0] m;
    logic [7:0]  e;
    bit          s;
    logic [31:0] r;
    bit          ov, un;
    int          lat, p;
    for (int i = 0; i < 200; i++) begin
      p = $urandom_range(0, 25);
      m = (p == 25) ? 25'h0 : ((25'h1 << p) | (25'($urandom) & ((25'h1 << p) - 25'h1)));
      e = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 255));
      s = 1'($urandom);
      model(m, int'(e), s, r, ov, un, lat);
      run_directed($sformatf("rand%0d_m%h_e%0d", i, m, e), m, e, s, r, ov, un, lat);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.mant_in   = '0;
    bus.exp_in    = '0;
    bus.sign_in   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_flags();
    test_zero_hold();
    test_reset_mid_norm();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
